// File: rtl/viterbi_frame_ctrl_if.sv
// Control/data bundle between the frame controller (slave) and the test harness (master).
interface viterbi_frame_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             start_i;
   logic [CNT_W-1:0] n_frames_i;
   logic             inj_en_i;
   logic             data_i;
   logic             data_req_o;
   logic             enc_en_o;
   logic             enc_bit_o;
   logic             inj_o;
   logic             dec_bit_i;
   logic             busy_o;
   logic             done_o;
   logic [CNT_W-1:0] frame_ct_o;
   logic [CNT_W-1:0] err_ct_o;
   logic [CNT_W-1:0] inj_ct_o;

   modport master (
      output start_i, n_frames_i, inj_en_i, data_i, dec_bit_i,
      input  data_req_o, enc_en_o, enc_bit_o, inj_o, busy_o, done_o,
             frame_ct_o, err_ct_o, inj_ct_o
   );

   modport slave (
      input  start_i, n_frames_i, inj_en_i, data_i, dec_bit_i,
      output data_req_o, enc_en_o, enc_bit_o, inj_o, busy_o, done_o,
             frame_ct_o, err_ct_o, inj_ct_o
   );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the encoder/channel/Viterbi chain: payload + zero tail, burst injection, BER scoring.
// Optional macro VFC_LFSR_INJ_EN: LFSR-driven window arming and burst offset.
module viterbi_frame_ctrl #(
   parameter int FRAME_LEN    = 64,
   parameter int TAIL_LEN     = 2,
   parameter int DEC_LAT      = 16,
   parameter int BURST_PERIOD = 32,
   parameter int BURST_LEN    = 2,
   parameter int CNT_W        = 16
) (
   input logic                 clk,
   input logic                 rst,
   viterbi_frame_ctrl_if.slave bus
);
   typedef enum logic [2:0] {S_IDLE, S_PAYLOAD, S_TAIL, S_DRAIN, S_DONE} state_t;

   localparam int SEQ_MAX = (FRAME_LEN > TAIL_LEN)
                          ? ((FRAME_LEN > DEC_LAT) ? FRAME_LEN : DEC_LAT)
                          : ((TAIL_LEN > DEC_LAT) ? TAIL_LEN : DEC_LAT);
   localparam int SEQ_W = $clog2(SEQ_MAX + 1);
   localparam int PH_W  = (BURST_PERIOD > 1) ? $clog2(BURST_PERIOD) : 1;

   localparam logic [SEQ_W-1:0] FRAME_LAST = SEQ_W'(FRAME_LEN - 1);
   localparam logic [SEQ_W-1:0] TAIL_LAST  = SEQ_W'(TAIL_LEN - 1);
   localparam logic [SEQ_W-1:0] DRAIN_LAST = SEQ_W'(DEC_LAT - 1);
   localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(BURST_PERIOD - 1);
   localparam logic [PH_W:0]    BURST_SPAN = (PH_W + 1)'(BURST_LEN);

   state_t           state_q, state_d;
   logic [SEQ_W-1:0] seq_q, seq_d;
   logic [CNT_W-1:0] n_frames_q, n_frames_d;
   logic [CNT_W-1:0] frame_ct_q, frame_ct_d;
   logic [CNT_W-1:0] err_ct_q, err_ct_d;
   logic [CNT_W-1:0] inj_ct_q, inj_ct_d;
   logic             inj_en_q, inj_en_d;
   logic [PH_W-1:0]  phase_q, phase_d;
   logic             inj_prev_q, inj_prev_d;
   logic [DEC_LAT-1:0] ref_v_q, ref_v_d;
   logic [DEC_LAT-1:0] ref_b_q, ref_b_d;

   logic            payload, run, enc_bit, in_burst, inj, win_armed, run_start;
   logic [PH_W:0]   win_off;

   assign payload   = (state_q == S_PAYLOAD);
   assign run       = payload || (state_q == S_TAIL);
   assign enc_bit   = payload & bus.data_i;
   assign run_start = (state_q == S_IDLE) && bus.start_i && (bus.n_frames_i != '0);

   // Burst never wraps into the next window: offset+BURST_LEN <= BURST_PERIOD by construction.
   assign in_burst = ({1'b0, phase_q} >= win_off) && ({1'b0, phase_q} < (win_off + BURST_SPAN));
   assign inj      = run & inj_en_q & win_armed & in_burst;

`ifdef VFC_LFSR_INJ_EN
   localparam int          OFF_MOD   = BURST_PERIOD - BURST_LEN + 1;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   logic [15:0] lfsr_q, lfsr_d;
   logic [16:0] off_full;

   assign off_full  = {9'd0, lfsr_q[15:8]} % 17'(OFF_MOD);
   assign win_armed = lfsr_q[0];
   assign win_off   = (PH_W + 1)'(off_full);

   // Step on the wrap into phase 0 so each window sees one stable LFSR value.
   always_comb begin
      lfsr_d = lfsr_q;
      if (run_start) begin
         lfsr_d = LFSR_SEED;
      end else if (run && (phase_q == PH_LAST)) begin
         lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) lfsr_q <= LFSR_SEED;
      else      lfsr_q <= lfsr_d;
   end
`else
   assign win_armed = 1'b1;
   assign win_off   = '0;
`endif

   always_comb begin
      state_d    = state_q;
      seq_d      = seq_q;
      n_frames_d = n_frames_q;
      frame_ct_d = frame_ct_q;
      err_ct_d   = err_ct_q;
      inj_ct_d   = inj_ct_q;
      inj_en_d   = inj_en_q;
      phase_d    = phase_q;
      inj_prev_d = inj;

      // Only payload bits enter the reference pipe as valid; tail bits are never scored.
      ref_v_d[0] = payload;
      ref_b_d[0] = enc_bit;
      for (int i = 1; i < DEC_LAT; i++) begin
         ref_v_d[i] = ref_v_q[i-1];
         ref_b_d[i] = ref_b_q[i-1];
      end

      if (ref_v_q[DEC_LAT-1] && (bus.dec_bit_i != ref_b_q[DEC_LAT-1]) && (err_ct_q != '1))
         err_ct_d = err_ct_q + 1'b1;
      if (inj && !inj_prev_q && (inj_ct_q != '1))
         inj_ct_d = inj_ct_q + 1'b1;
      if (run)
         phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            if (run_start) begin
               state_d    = S_PAYLOAD;
               seq_d      = '0;
               n_frames_d = bus.n_frames_i;
               inj_en_d   = bus.inj_en_i;
               frame_ct_d = '0;
               err_ct_d   = '0;
               inj_ct_d   = '0;
               phase_d    = '0;
               ref_v_d    = '0;
               ref_b_d    = '0;
            end else if (bus.start_i) begin
               state_d = S_DONE;
            end
         end
         S_PAYLOAD: begin
            if (seq_q == FRAME_LAST) begin
               seq_d   = '0;
               state_d = S_TAIL;
            end else begin
               seq_d = seq_q + 1'b1;
            end
         end
         S_TAIL: begin
            if (seq_q == TAIL_LAST) begin
               seq_d      = '0;
               frame_ct_d = frame_ct_q + 1'b1;
               state_d    = ((frame_ct_q + 1'b1) == n_frames_q) ? S_DRAIN : S_PAYLOAD;
            end else begin
               seq_d = seq_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (seq_q == DRAIN_LAST) begin
               seq_d   = '0;
               state_d = S_DONE;
            end else begin
               seq_d = seq_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         seq_q      <= '0;
         n_frames_q <= '0;
         frame_ct_q <= '0;
         err_ct_q   <= '0;
         inj_ct_q   <= '0;
         inj_en_q   <= 1'b0;
         phase_q    <= '0;
         inj_prev_q <= 1'b0;
         ref_v_q    <= '0;
         ref_b_q    <= '0;
      end else begin
         state_q    <= state_d;
         seq_q      <= seq_d;
         n_frames_q <= n_frames_d;
         frame_ct_q <= frame_ct_d;
         err_ct_q   <= err_ct_d;
         inj_ct_q   <= inj_ct_d;
         inj_en_q   <= inj_en_d;
         phase_q    <= phase_d;
         inj_prev_q <= inj_prev_d;
         ref_v_q    <= ref_v_d;
         ref_b_q    <= ref_b_d;
      end
   end

   assign bus.data_req_o = payload;
   assign bus.enc_en_o   = run;
   assign bus.enc_bit_o  = enc_bit;
   assign bus.inj_o      = inj;
   assign bus.busy_o     = run || (state_q == S_DRAIN);
   assign bus.done_o     = (state_q == S_DONE);
   assign bus.frame_ct_o = frame_ct_q;
   assign bus.err_ct_o   = err_ct_q;
   assign bus.inj_ct_o   = inj_ct_q;
endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed bench for viterbi_frame_ctrl with default parameters and an ideal/stuck decoder model.
module tb_viterbi_frame_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   viterbi_frame_ctrl_if #(.CNT_W(16)) bus ();

   viterbi_frame_ctrl #(
      .FRAME_LEN(64), .TAIL_LEN(2), .DEC_LAT(16),
      .BURST_PERIOD(32), .BURST_LEN(2), .CNT_W(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Decoder model: ideal = encoder input delayed 16 cycles; stuck = constant 1.
   logic [15:0] dly = '0;
   logic        dmode = 1'b0;
   always @(posedge clk) dly <= {dly[14:0], bus.enc_bit_o};
   assign bus.dec_bit_i = dmode ? 1'b1 : dly[15];

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   int en_first, en_last, en_cnt, tail_cnt, tail_bad, pass_bad;
   int done_cyc, done_cnt, inj_cnt, inj_hit;
   logic [31:0] fin_frame, fin_err, fin_inj, fin_busy;
   logic [31:0] pre_en, pre_injct, post_busy, post_en, post_frame, post_err, post_injct;

   task automatic run(input string name, input logic [15:0] nf, input logic ie, input logic dm,
                      input bit pat, input int pulse_at, input int rst_at);
      int stop;
      en_first = 0; en_last = 0; en_cnt = 0; tail_cnt = 0; tail_bad = 0; pass_bad = 0;
      done_cyc = -1; done_cnt = 0; inj_cnt = 0; inj_hit = 0;
      stop = (rst_at > 0) ? rst_at + 10 : 400;
      dmode = dm;
      bus.n_frames_i = nf;
      bus.inj_en_i   = ie;
      bus.start_i    = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      for (int c = 1; c <= stop; c++) begin
         bus.data_i  = pat ? ((c >= 65) ? 1'b1 : ((c % 3) == 1)) : 1'b0;
         bus.start_i = (c == pulse_at);
         if (c == pulse_at) bus.n_frames_i = 16'd3;
         rst = (c == rst_at) ? 1'b0 : 1'b1;
         #2;
         if (bus.enc_en_o) begin
            if (en_first == 0) en_first = c;
            en_last = c;
            en_cnt++;
         end
         if (bus.enc_en_o && !bus.data_req_o) begin
            tail_cnt++;
            if (bus.enc_bit_o !== 1'b0) tail_bad++;
         end
         if (bus.data_req_o && (bus.enc_bit_o !== bus.data_i)) pass_bad++;
         if (bus.inj_o) begin
            inj_cnt++;
            if (c inside {1, 2, 33, 34, 65, 66}) inj_hit++;
         end
         if (bus.done_o) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc = c;
               stop = c + 1;
            end
         end
         if (c == rst_at) begin
            pre_en    = 32'(bus.enc_en_o);
            pre_injct = 32'(bus.inj_ct_o);
         end
         if (c == rst_at + 1) begin
            post_busy  = 32'(bus.busy_o);
            post_en    = 32'(bus.enc_en_o);
            post_frame = 32'(bus.frame_ct_o);
            post_err   = 32'(bus.err_ct_o);
            post_injct = 32'(bus.inj_ct_o);
         end
         @(posedge clk); #1;
      end
      bus.start_i = 1'b0;
      rst       = 1'b1;
      fin_frame = 32'(bus.frame_ct_o);
      fin_err   = 32'(bus.err_ct_o);
      fin_inj   = 32'(bus.inj_ct_o);
      fin_busy  = 32'(bus.busy_o);
      $display("run %s: frames=%0d errs=%0d bursts=%0d enc_cycles=%0d done_at=%0d",
               name, fin_frame, fin_err, fin_inj, en_cnt, done_cyc);
   endtask

   task automatic check_clean(input string p);
      chk({p, "_en_first"}, en_first, 1);
      chk({p, "_en_last"}, en_last, 66);
      chk({p, "_en_cnt"}, en_cnt, 66);
      chk({p, "_tail_cnt"}, tail_cnt, 2);
      chk({p, "_tail_zero"}, tail_bad, 0);
      chk({p, "_passthru"}, pass_bad, 0);
      chk({p, "_done_cyc"}, done_cyc, 83);
      chk({p, "_done_cnt"}, done_cnt, 1);
      chk({p, "_frame_ct"}, fin_frame, 1);
      chk({p, "_err_ct"}, fin_err, 0);
      chk({p, "_inj_ct"}, fin_inj, 0);
      chk({p, "_inj_cycles"}, inj_cnt, 0);
      chk({p, "_idle_after"}, fin_busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      bus.start_i = 1'b1; bus.n_frames_i = 16'd5; bus.inj_en_i = 1'b1;
      bus.data_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(bus.busy_o), 0);
      chk("rst_done", 32'(bus.done_o), 0);
      chk("rst_enc_en", 32'(bus.enc_en_o), 0);
      chk("rst_enc_bit", 32'(bus.enc_bit_o), 0);
      chk("rst_data_req", 32'(bus.data_req_o), 0);
      chk("rst_inj", 32'(bus.inj_o), 0);
      chk("rst_counters", {bus.frame_ct_o, bus.err_ct_o | bus.inj_ct_o}, 0);
      rst = 1'b1;
      bus.start_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("release_busy", 32'(bus.busy_o), 0);
      chk("release_enc_en", 32'(bus.enc_en_o), 0);
      $display("run reset: busy=%0d enc_en=%0d", bus.busy_o, bus.enc_en_o);

      run("zero_frames", 16'd0, 1'b0, 1'b0, 1'b1, 0, 0);
      chk("zero_done_cyc", done_cyc, 1);
      chk("zero_done_cnt", done_cnt, 1);
      chk("zero_en_cnt", en_cnt, 0);
      chk("zero_frame_ct", fin_frame, 0);
      chk("zero_err_ct", fin_err, 0);

      run("clean", 16'd1, 1'b0, 1'b0, 1'b1, 0, 0);
      check_clean("clean");

      run("mismatch", 16'd2, 1'b0, 1'b1, 1'b0, 0, 0);
      chk("mism_err_ct", fin_err, 128);
      chk("mism_frame_ct", fin_frame, 2);
      chk("mism_en_first", en_first, 1);
      chk("mism_en_last", en_last, 132);
      chk("mism_en_cnt", en_cnt, 132);
      chk("mism_tail_cnt", tail_cnt, 4);
      chk("mism_done_cyc", done_cyc, 149);

      run("inject", 16'd1, 1'b1, 1'b0, 1'b1, 0, 0);
      chk("inj_cycles", inj_cnt, 6);
      chk("inj_expected_hits", inj_hit, 6);
      chk("inj_ct", fin_inj, 3);
      chk("inj_err_ct", fin_err, 0);
      chk("inj_done_cyc", done_cyc, 83);

      run("start_pulse", 16'd1, 1'b0, 1'b0, 1'b1, 10, 0);
      chk("pulse_frame_ct", fin_frame, 1);
      chk("pulse_en_cnt", en_cnt, 66);
      chk("pulse_done_cyc", done_cyc, 83);

      run("mid_reset", 16'd1, 1'b1, 1'b0, 1'b1, 0, 11);
      chk("midrst_pre_en", pre_en, 1);
      chk("midrst_pre_inj_ct", pre_injct, 1);
      chk("midrst_busy", post_busy, 0);
      chk("midrst_enc_en", post_en, 0);
      chk("midrst_frame_ct", post_frame, 0);
      chk("midrst_err_ct", post_err, 0);
      chk("midrst_inj_ct", post_injct, 0);
      chk("midrst_no_done", done_cnt, 0);

      run("rerun", 16'd1, 1'b0, 1'b0, 1'b1, 0, 0);
      check_clean("rerun");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
